// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: multiplexed N-digit seven-segment scanner with double buffering, LZ blanking, anti-ghost blank and PWM dimming
// clk, reset         : clock, synchronous active-high reset
// data, dp, digit_en : staged on load, committed to the display at the next frame boundary
// lz_blank, brightness : live controls (leading-zero blanking, duty (brightness+1)/16)
// seg, dp_n, AN      : registered active-low cathodes/anodes
// digit_idx          : slot currently scanned; frame_tick pulses the cycle after each frame boundary
module sseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 64,
  parameter int IDX_W        = 3,
  parameter int CNT_W        = 17
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  input  logic [3:0]              brightness,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_tick
);
  logic [CNT_W-1:0]        pcnt_q, pcnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [3:0]              pwm_q;
  logic                    stg_valid_q;
  logic [4*NUM_DIGITS-1:0] stg_data_q, act_data_q;
  logic [NUM_DIGITS-1:0]   stg_dp_q, stg_en_q, act_dp_q, act_en_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dpn_q, dpn_d, ftick_q;
  logic                    slot_end, frame_end, commit, sup, lit;
  logic [3:0]              nib;

  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    slot_end  = pcnt_q == CNT_W'(REFRESH_DIV - 1);
    frame_end = slot_end && idx_q == IDX_W'(NUM_DIGITS - 1);
    commit    = frame_end && stg_valid_q;
    pcnt_d    = slot_end ? '0 : pcnt_q + 1'b1;
    idx_d     = frame_end ? '0 : slot_end ? idx_q + 1'b1 : idx_q;
    nib       = act_data_q[idx_q*4 +: 4];
    // digit k is a leading zero iff every nibble from k upward is zero
    sup       = lz_blank && idx_q != '0 && (act_data_q >> {idx_q, 2'b00}) == '0;
    lit       = pcnt_q >= CNT_W'(BLANK_CYCLES) && pwm_q <= brightness && act_en_q[idx_q] && !sup;
    an_d      = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    seg_d     = lit ? decode(nib) : 7'h7F;
    dpn_d     = lit ? ~act_dp_q[idx_q] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q      <= '0;
      idx_q       <= '0;
      pwm_q       <= '0;
      stg_valid_q <= 1'b0;
      stg_data_q  <= '0;
      stg_dp_q    <= '0;
      stg_en_q    <= '1;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      act_en_q    <= '1;
      an_q        <= '1;
      seg_q       <= 7'h7F;
      dpn_q       <= 1'b1;
      ftick_q     <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      idx_q   <= idx_d;
      pwm_q   <= pwm_q + 1'b1;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dpn_q   <= dpn_d;
      ftick_q <= frame_end;
      if (commit) begin
        act_data_q <= stg_data_q;
        act_dp_q   <= stg_dp_q;
        act_en_q   <= stg_en_q;
      end
      // a load on the commit edge refills staging for the following frame
      if (load) begin
        stg_data_q  <= data;
        stg_dp_q    <= dp;
        stg_en_q    <= digit_en;
        stg_valid_q <= 1'b1;
      end else if (commit) begin
        stg_valid_q <= 1'b0;
      end
    end
  end

  assign seg        = seg_q;
  assign dp_n       = dpn_q;
  assign AN         = an_q;
  assign digit_idx  = idx_q;
  assign frame_tick = ftick_q;
endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Parametrised multiplexed seven-segment display controller for N hex digits.
- Integrated refresh prescaler: no external tick input.
- Adds tear-free double-buffered updates, per-digit decimal points and enables, leading-zero blanking, an inter-digit anti-ghosting blank interval and 16-level PWM brightness.
- Sits between the system data/status registers and the board's anode/cathode pins.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (1..16).
- REFRESH_DIV, 100000, clk cycles per digit slot (>= BLANK_CYCLES+2).
- BLANK_CYCLES, 64, cycles at start of each slot with all anodes off (>= 1).
- IDX_W, 3, width of digit index; must be >= max(1, clog2(NUM_DIGITS)).
- CNT_W, 17, prescaler width; must hold REFRESH_DIV-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- data  in  4*NUM_DIGITS  hex nibbles; digit i = data[4i+3:4i]
- dp  in  NUM_DIGITS  decimal point request per digit, 1 = lit
- digit_en  in  NUM_DIGITS  per-digit enable, 0 = digit dark
- lz_blank  in  1  leading-zero blanking enable
- brightness  in  4  duty = (brightness+1)/16 of the on-window
- load  in  1  one-cycle strobe: capture data/dp/digit_en into staging
- seg  out  7  cathodes, active-low, seg[0]=a .. seg[6]=g
- dp_n  out  1  decimal-point cathode, active-low
- AN  out  NUM_DIGITS  anodes, active-low, one-hot-low when lit
- digit_idx  out  IDX_W  digit slot currently scanned
- frame_tick  out  1  one-cycle pulse at each frame start

Behaviour:
- Reset (sync, clk edge with reset=1):
  - pcnt=0, digit_idx=0, pwm_cnt=0, staging_valid=0.
  - Active and staging regs: data=0, dp=0, digit_en=all-ones.
  - Outputs: AN=all-ones, seg=7'h7F, dp_n=1, frame_tick=0.
  - Reset mid-frame aborts the scan; the display is dark the cycle after the reset edge.
- Prescaler: pcnt counts 0..REFRESH_DIV-1 then wraps to 0. On that wrap:
  - digit_idx increments; after NUM_DIGITS-1 it wraps to 0.
  - The idx wrap edge is the frame boundary.
- frame_tick: registered. High for exactly the one cycle following a frame-boundary edge; never asserted out of reset alone.
- Load and buffering:
  - load=1 at an edge captures data, dp and digit_en into staging and sets staging_valid.
  - At a frame boundary with staging_valid=1: active<=staging, staging_valid<=0.
  - load coincident with a frame boundary: the old staging is committed and the new value goes to staging, appearing next frame.
  - Multiple loads in one frame: the last one wins.
- PWM: pwm_cnt is a 4-bit free-running counter incrementing every cycle. pwm_on = (pwm_cnt <= brightness).
- Lit condition for digit k = digit_idx, all of:
  - pcnt >= BLANK_CYCLES
  - pwm_on
  - active digit_en[k]=1
  - not lz-suppressed
- LZ suppression:
  - Applies only when lz_blank=1, k != 0, and active nibbles k..NUM_DIGITS-1 are all zero.
  - Digit 0 is never suppressed.
  - A suppressed digit shows no dp.
- Output values:
  - Lit: AN bit k=0 (others 1), seg=decode(nibble k), dp_n=~dp[k].
  - Otherwise: AN=all-ones, seg=7'h7F, dp_n=1. Blanking cathodes while dark prevents ghosting.
- Decode table (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. F renders as 'F' and is not blanked.
- Latency: AN/seg/dp_n are registered, one cycle after the pcnt/digit_idx/pwm_cnt state that selects them. digit_idx is output directly from its register.
- brightness, lz_blank: sampled live, not buffered.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, IDX_W=2, CNT_W=3 unless noted):
- Reset, no load, brightness=15: digit_idx steps 0,1,2,3,0 every 8 cycles. Each slot: AN=1111 for 2 cycles, then AN bit k low for 6 cycles with seg=1000000. frame_tick pulses once per 32 cycles.
- load data=16'h1F3A, dp=4'b0100, en=4'hF mid-frame: display unchanged until the frame boundary. Next frame: digit0 seg=0001000, digit1 seg=0110000, digit2 seg=0001110 with dp_n=0, digit3 seg=1111001.
- lz_blank=1, data=16'h0050: digit3 and digit2 dark (AN=1111 in their slots); digit1 shows 5; digit0 shows 0. data=16'h0000: only digit0 lit, showing 0.
- brightness=3: within each on-window, AN low only in cycles where pwm_cnt<=3, i.e. 4 of every 16 cycles; seg=7F when AN high.
- digit_en=4'b1010 loaded: slots 0 and 2 fully dark, slot timing unchanged. Load asserted on a frame-boundary edge commits one frame later.
- reset pulsed in slot 2 at pcnt=5: next cycle AN=1111, seg=7F, digit_idx=0, staged-but-uncommitted data discarded.
